// File: rtl/bch_pkg.sv
// Shared BCH(63,56) constants and the remainder-update step, also used by the
// downstream syndrome-split stage.
package bch_pkg;

  localparam int N     = 63;
  localparam int K     = 56;
  localparam int R     = 7;
  localparam int CNT_W = 6;

  // g(x) = x^7 + x^6 + x^2 + 1, x^7 implicit
  localparam logic [R-1:0] GPOLY = 7'b1000101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [R-1:0] lfsr_step(input logic [R-1:0] rem, input logic din);
    logic [R-1:0] nxt;
    nxt = {rem[R-2:0], din};
    if (rem[R-1]) begin
      nxt = nxt ^ GPOLY;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bch_syndrome_calc_if.sv
// Bit-serial codeword input and syndrome/codeword result bundle.
// par_err is present only when BCH_PARITY_CHK_EN is defined.
interface bch_syndrome_calc_if;
  import bch_pkg::*;

  logic         sof;
  logic         din;
  logic         isEn1;
  logic [R-1:0] S;
  logic [N-1:0] cw;
  logic         isEn2;
  logic         busy;
`ifdef BCH_PARITY_CHK_EN
  logic         par_err;

  modport master (output sof, din, isEn1, input S, cw, isEn2, busy, par_err);
  modport slave  (input sof, din, isEn1, output S, cw, isEn2, busy, par_err);
`else
  modport master (output sof, din, isEn1, input S, cw, isEn2, busy);
  modport slave  (input sof, din, isEn1, output S, cw, isEn2, busy);
`endif

endinterface

// File: rtl/bch_lfsr_div.sv
// R-bit remainder register dividing the serial input by g(x). clr_i restarts
// the division so that the bit presented in the same cycle is absorbed from zero.
module bch_lfsr_div
  import bch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         din_i,
  output logic [R-1:0] rem_nxt_o
);

  logic [R-1:0] rem_q;
  logic [R-1:0] rem_d;
  logic [R-1:0] base_s;

  // remainder after absorbing din_i, and the next register value
  always_comb begin
    base_s    = clr_i ? {R{1'b0}} : rem_q;
    rem_nxt_o = lfsr_step(base_s, din_i);
    if (en_i) begin
      rem_d = rem_nxt_o;
    end else begin
      rem_d = base_s;
    end
  end

  // remainder register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= {R{1'b0}};
    end else begin
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/bch_syndrome_calc.sv
// BCH(63,56) serial syndrome front end: absorbs one bit per isEn1, then strobes
// isEn2 with S and the buffered codeword. BCH_PARITY_CHK_EN adds par_err.
module bch_syndrome_calc
  import bch_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  bch_syndrome_calc_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     cw_q, cw_d;
  logic [R-1:0]     s_q, s_d;
  logic             isen2_q, isen2_d;
  logic             busy_q, busy_d;
  logic [R-1:0]     rem_nxt_s;
  logic             start_s;
  logic             accum_bit_s;
  logic             last_s;
`ifdef BCH_PARITY_CHK_EN
  logic             par_acc_q, par_acc_d;
  logic             par_err_q, par_err_d;
`endif

  // sof restarts a frame from any state, aborting one in progress
  assign start_s     = bus.isEn1 & bus.sof;
  assign accum_bit_s = bus.isEn1 & ~bus.sof & (state_q == ST_ACCUM);
  assign last_s      = accum_bit_s & (cnt_q == LAST_CNT);

  bch_lfsr_div u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (start_s),
    .en_i      (start_s | accum_bit_s),
    .din_i     (bus.din),
    .rem_nxt_o (rem_nxt_s)
  );

  // next-state, counter, codeword buffer and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cw_d    = cw_q;
    s_d     = s_q;
    isen2_d = 1'b0;
`ifdef BCH_PARITY_CHK_EN
    par_acc_d = par_acc_q;
    par_err_d = par_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_s) state_d = ST_ACCUM;
        else         state_d = ST_IDLE;
      end
      ST_ACCUM: begin
        if (start_s)     state_d = ST_ACCUM;
        else if (last_s) state_d = ST_DONE;
        else             state_d = ST_ACCUM;
      end
      ST_DONE: begin
        if (start_s) state_d = ST_ACCUM;
        else         state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_s) begin
      cnt_d = CNT_ONE;
      cw_d  = {{(N-1){1'b0}}, bus.din};
`ifdef BCH_PARITY_CHK_EN
      par_acc_d = bus.din;
`endif
    end else if (accum_bit_s) begin
      cw_d = {cw_q[N-2:0], bus.din};
`ifdef BCH_PARITY_CHK_EN
      par_acc_d = par_acc_q ^ bus.din;
`endif
      if (last_s) begin
        cnt_d   = {CNT_W{1'b0}};
        s_d     = rem_nxt_s;
        isen2_d = 1'b1;
`ifdef BCH_PARITY_CHK_EN
        par_err_d = par_acc_q ^ bus.din;
`endif
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end

    busy_d = (state_d == ST_ACCUM);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      cw_q    <= {N{1'b0}};
      s_q     <= {R{1'b0}};
      isen2_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BCH_PARITY_CHK_EN
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cw_q    <= cw_d;
      s_q     <= s_d;
      isen2_q <= isen2_d;
      busy_q  <= busy_d;
`ifdef BCH_PARITY_CHK_EN
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  assign bus.S     = s_q;
  assign bus.cw    = cw_q;
  assign bus.isEn2 = isen2_q;
  assign bus.busy  = busy_q;
`ifdef BCH_PARITY_CHK_EN
  assign bus.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_bch_syndrome_calc.sv
// Directed bench for bch_syndrome_calc; expected syndromes are hand-derived
// remainders of r(x) mod x^7+x^6+x^2+1.
module tb_bch_syndrome_calc;
  import bch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  bch_syndrome_calc_if bus();

  bch_syndrome_calc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cyc = 0;
  int pulse_cyc = 0;
  int prev_pulse_cyc = 0;

  // count isEn2 pulses and remember the cycles of the last two
  always @(posedge clk) begin
    #1;
    cyc <= cyc + 1;
    if (bus.isEn2 === 1'b1) begin
      pulses         <= pulses + 1;
      prev_pulse_cyc <= pulse_cyc;
      pulse_cyc      <= cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic d, input logic e);
    @(negedge clk);
    bus.sof   = s;
    bus.din   = d;
    bus.isEn1 = e;
  endtask

  // send the first nbits of bits, r62 first; now=1 drives bit r62 immediately
  task automatic send_bits(input logic [62:0] bits, input int nbits, input bit gaps, input bit now);
    for (int i = 0; i < nbits; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
        drive(1'b0, 1'b1, 1'b0);
      end
      if (now && i == 0) begin
        bus.sof   = 1'b1;
        bus.din   = bits[62];
        bus.isEn1 = 1'b1;
      end else begin
        drive(i == 0, bits[62 - i], 1'b1);
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [6:0] exp_s, input logic [62:0] bits);
    logic exp_par;
    exp_par = ^bits;
    @(negedge clk);
    check({tag, ".isEn2"}, {63'd0, bus.isEn2}, 64'd1);
    check({tag, ".S"}, {57'd0, bus.S}, {57'd0, exp_s});
    check({tag, ".cw"}, {1'b0, bus.cw}, {1'b0, bits});
    check({tag, ".busy"}, {63'd0, bus.busy}, 64'd0);
`ifdef BCH_PARITY_CHK_EN
    check({tag, ".par_err"}, {63'd0, bus.par_err}, {63'd0, exp_par});
`endif
    bus.sof   = 1'b0;
    bus.din   = 1'b0;
    bus.isEn1 = 1'b0;
  endtask

  task automatic after_frame(input string tag, input int exp_pulses);
    @(negedge clk);
    check({tag, ".isEn2_low"}, {63'd0, bus.isEn2}, 64'd0);
    check({tag, ".pulses"}, 64'(pulses), 64'(exp_pulses));
  endtask

  localparam logic [62:0] ZERO  = 63'd0;
  localparam logic [62:0] R0    = 63'h1;
  localparam logic [62:0] R7    = 63'h80;
  localparam logic [62:0] GCW   = 63'hC5;
  localparam logic [62:0] ONES  = {63{1'b1}};

  initial begin
    rst_n     = 1'b0;
    bus.sof   = 1'b0;
    bus.din   = 1'b0;
    bus.isEn1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.S", {57'd0, bus.S}, 64'd0);
    check("rst.cw", {1'b0, bus.cw}, 64'd0);
    check("rst.isEn2", {63'd0, bus.isEn2}, 64'd0);
    check("rst.busy", {63'd0, bus.busy}, 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("idle_no_sof.busy", {63'd0, bus.busy}, 64'd0);

    send_bits(ZERO, 63, 1'b0, 1'b0);
    check_frame("zero", 7'h00, ZERO);
    after_frame("zero", 1);

    send_bits(R0, 63, 1'b0, 1'b0);
    check_frame("r0", 7'b0000001, R0);
    after_frame("r0", 2);

    send_bits(R7, 63, 1'b0, 1'b0);
    check_frame("r7", 7'b1000101, R7);
    after_frame("r7", 3);

    // reset in the middle of a frame
    send_bits(ONES, 40, 1'b0, 1'b0);
    @(negedge clk);
    check("mid.busy", {63'd0, bus.busy}, 64'd1);
    rst_n     = 1'b0;
    bus.isEn1 = 1'b1;
    bus.din   = 1'b1;
    @(negedge clk);
    rst_n     = 1'b1;
    bus.isEn1 = 1'b0;
    check("rst40.S", {57'd0, bus.S}, 64'd0);
    check("rst40.cw", {1'b0, bus.cw}, 64'd0);
    check("rst40.isEn2", {63'd0, bus.isEn2}, 64'd0);
    check("rst40.busy", {63'd0, bus.busy}, 64'd0);
    send_bits(R0, 63, 1'b0, 1'b0);
    check_frame("post_rst", 7'b0000001, R0);
    after_frame("post_rst", 4);

    send_bits(GCW, 63, 1'b1, 1'b0);
    check_frame("gpoly_gaps", 7'h00, GCW);
    after_frame("gpoly_gaps", 5);

    // sof again at bit 30 discards the partial frame
    send_bits(ONES, 30, 1'b0, 1'b0);
    send_bits(ZERO, 63, 1'b0, 1'b0);
    check_frame("restart", 7'h00, ZERO);
    after_frame("restart", 6);

    // back-to-back with sof in the DONE cycle
    send_bits(R7, 63, 1'b0, 1'b0);
    check_frame("b2b_a", 7'b1000101, R7);
    send_bits(R0, 63, 1'b0, 1'b1);
    check_frame("b2b_b", 7'b0000001, R0);
    after_frame("b2b_b", 8);
    check("b2b.spacing", 64'(pulse_cyc - prev_pulse_cyc), 64'd63);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
